im2col_addr_seq: RTL
====================

# im2col_addr_seq

Address sequencer for the im2col convolution datapath. It latches the layer parameters that the control unit has registered (tensor size, kernel size, channels, stride), computes the output feature size, and then walks every im2col matrix element, issuing one input-buffer read address per handshake. When the last address is accepted it raises the `w_done` / `n_para_done` / `n_ofs` feedback that the control unit uses to chain the next layer.

## Interface
Parameters:
- `TS_W`, default 8: tensor size width.
- `KS_W`, default 4: kernel size width.
- `CH_W`, default 8: channel count width.
- `ST_W`, default 3: stride width.
- `ADDR_W`, default 16: read address width.

Ports:
- `clk`  in  1: system clock. This is the only clock.
- `rstn`  in  1: reset, asynchronous and active-low.
- `enable`  in  1: global enable. When low, all registers hold.
- `start_conv`  in  1: level from the control unit. Its rising edge starts one layer.
- `tensor_size`  in  TS_W: input tensor edge T.
- `kernel_size`  in  KS_W: kernel edge K.
- `channels`  in  CH_W: input channel count C.
- `stride`  in  ST_W: stride S.
- `addr`  out  ADDR_W: input buffer read address. Registered.
- `addr_valid`  out  1: `addr` is valid.
- `addr_ready`  in  1: consumer accepts `addr`.
- `row_last`  out  1: `addr` is the last element of one im2col row.
- `n_ofs`  out  TS_W: output edge minus one, i.e. (T−K)/S, floor.
- `n_para_done`  out  1: one-cycle pulse when `n_ofs` becomes valid.
- `w_done`  out  1: one-cycle pulse after the last address is accepted.
- `cfg_err`  out  1: one-cycle pulse when the parameters are illegal.

## Operation
- FSM states: IDLE → CALC → RUN → DONE → IDLE.
- **IDLE.** On the rising edge of `start_conv`, latch T, K, C and S into shadow registers and go to CALC. If K > T, S == 0, C == 0 or K == 0, pulse `cfg_err` instead and stay in IDLE.
- **CALC.** Compute n_ofs by repeated subtraction, with no divider:
  - r = T−K, q = 0.
  - Each cycle: if r ≥ S, then r −= S and q++; otherwise leave CALC.
  - On exit, `n_ofs` = q and `n_para_done` pulses.
- **RUN.** Nested counters, from outer to inner: oy, ox ∈ [0, n_ofs]; c ∈ [0, C−1]; ky, kx ∈ [0, K−1].
  - addr = c·T² + (oy·S + ky)·T + (ox·S + kx), truncated to ADDR_W.
  - Addresses are generated incrementally from base registers: channel base += T², row base += T, column += 1.
  - One im2col row is C·K² addresses. `row_last` = (c == C−1 && ky == K−1 && kx == K−1).
  - Total addresses issued = (n_ofs+1)² · C · K².
- **DONE.** Pulse `w_done` for one cycle, then return to IDLE. `n_ofs` holds its value until the next CALC.
- `start_conv` edges outside IDLE are ignored. The edge detector still tracks the level, so a level held high across DONE does not retrigger.

## Timing
- Reset values: `addr` = 0, `addr_valid` = 0, `row_last` = 0, `n_ofs` = 0, `n_para_done` = 0, `w_done` = 0, `cfg_err` = 0. The FSM resets to IDLE and the edge-detect register to 0.
- The `start_conv` edge is seen in cycle t. CALC is active from t+1 and lasts q+1 cycles.
- `n_para_done` is high in the first RUN cycle. `addr_valid` rises in that same cycle with addr = 0 (oy = ox = c = ky = kx = 0).
- Handshake:
  - A transfer happens on a cycle with `addr_valid && addr_ready`.
  - `addr`, `row_last` and `addr_valid` stay stable while `addr_ready` is low.
  - With `addr_ready` held high, one address is issued per cycle and there are no bubbles, including across row and channel wraps.
- `w_done` is high exactly one cycle after the final transfer. `addr_valid` is low in that cycle.
- `enable` low freezes all state, including the handshake outputs. A transfer is not counted while `enable` is low.
- If `rstn` is asserted mid-RUN, everything returns to its reset values immediately, with no `w_done`.

## Configuration
- Macro: `IM2COL_STALL_CNT_EN`.
- Defined: adds output `stall_cnt` (16 bits, reset 0).
  - Cleared on entry to CALC.
  - Increments each enabled cycle with `addr_valid && !addr_ready`.
  - Saturates at 0xFFFF.
- Undefined: no port and no logic.

## Test plan
- T=4, K=3, S=1, C=1, `addr_ready` = 1: `n_ofs` = 1, 36 addresses.
  - Row 0 is 0,1,2,4,5,6,8,9,10.
  - Row 1 starts 1,2,3.
  - `row_last` on every 9th address; `w_done` one cycle after the 36th.
- T=5, K=3, S=2, C=2: CALC takes 2 cycles and `n_ofs` = 1.
  - 72 addresses; address 9 = 25 (channel 1 base).
  - Row 1 (ox = 1) starts at address 2.
- Random `addr_ready` with ~50 % duty and the config from the first scenario: the address sequence is identical to the back-to-back run, `addr` is stable during stalls, and `stall_cnt` equals the number of stall cycles.
- K=5, T=4: `cfg_err` pulses in the cycle after the edge, with no `n_para_done`, no `addr_valid` and no `w_done`. Also check S=0 the same way.
- Reset after the 10th transfer: all outputs are 0 next cycle. A fresh `start_conv` edge restarts from addr 0.
- `start_conv` held high through DONE: no second run. Toggling it low then high starts a second run with newly latched parameters.

Source files
------------

// File: rtl/im2col_addr_seq.sv
// im2col read-address sequencer: latches layer parameters, derives the output edge by
// repeated subtraction, then walks every im2col element. `IM2COL_STALL_CNT_EN adds stall_cnt.
module im2col_addr_seq #(
    parameter int unsigned TS_W   = 8,
    parameter int unsigned KS_W   = 4,
    parameter int unsigned CH_W   = 8,
    parameter int unsigned ST_W   = 3,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic              start_conv,
    input  logic [TS_W-1:0]   tensor_size,
    input  logic [KS_W-1:0]   kernel_size,
    input  logic [CH_W-1:0]   channels,
    input  logic [ST_W-1:0]   stride,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              row_last,
    output logic [TS_W-1:0]   n_ofs,
    output logic              n_para_done,
    output logic              w_done,
    output logic              cfg_err
`ifdef IM2COL_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int unsigned CMP_W = (TS_W > KS_W) ? TS_W : KS_W;
    localparam int unsigned RS_W  = (TS_W > ST_W) ? TS_W : ST_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_RUN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic              start_q, start_d;
    logic [TS_W-1:0]   t_q, t_d;
    logic [KS_W-1:0]   k_q, k_d;
    logic [CH_W-1:0]   c_q, c_d;
    logic [ST_W-1:0]   s_q, s_d;
    logic [TS_W-1:0]   r_q, r_d;
    logic [TS_W-1:0]   q_q, q_d;
    logic [ADDR_W-1:0] tsq_q, tsq_d;
    logic [ADDR_W-1:0] st_q, st_d;

    logic [KS_W-1:0]   kx_q, kx_d;
    logic [KS_W-1:0]   ky_q, ky_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [TS_W-1:0]   ox_q, ox_d;
    logic [TS_W-1:0]   oy_q, oy_d;

    logic [ADDR_W-1:0] ch_base_q, ch_base_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] oy_row_q, oy_row_d;
    logic [ADDR_W-1:0] ox_col_q, ox_col_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              row_last_q, row_last_d;
    logic [TS_W-1:0]   n_ofs_q, n_ofs_d;
    logic              para_done_q, para_done_d;
    logic              w_done_q, w_done_d;
    logic              cfg_err_q, cfg_err_d;
`ifdef IM2COL_STALL_CNT_EN
    logic [15:0]       stall_q, stall_d;
`endif

    logic start_rise;
    logic cfg_bad;
    logic kx_last, ky_last, ch_last, ox_last, oy_last;

    assign start_rise = start_conv && !start_q;
    assign cfg_bad    = (CMP_W'(kernel_size) > CMP_W'(tensor_size)) || (stride == '0) ||
                        (channels == '0) || (kernel_size == '0);

    assign kx_last = (kx_q == k_q - KS_W'(1));
    assign ky_last = (ky_q == k_q - KS_W'(1));
    assign ch_last = (ch_q == c_q - CH_W'(1));
    assign ox_last = (ox_q == n_ofs_q);
    assign oy_last = (oy_q == n_ofs_q);

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        start_d     = start_conv;
        t_d         = t_q;
        k_d         = k_q;
        c_d         = c_q;
        s_d         = s_q;
        r_d         = r_q;
        q_d         = q_q;
        tsq_d       = tsq_q;
        st_d        = st_q;
        kx_d        = kx_q;
        ky_d        = ky_q;
        ch_d        = ch_q;
        ox_d        = ox_q;
        oy_d        = oy_q;
        ch_base_d   = ch_base_q;
        row_d       = row_q;
        col_d       = col_q;
        oy_row_d    = oy_row_q;
        ox_col_d    = ox_col_q;
        addr_d      = addr_q;
        valid_d     = valid_q;
        row_last_d  = row_last_q;
        n_ofs_d     = n_ofs_q;
        para_done_d = 1'b0;
        w_done_d    = 1'b0;
        cfg_err_d   = 1'b0;
`ifdef IM2COL_STALL_CNT_EN
        stall_d     = stall_q;
        if (valid_q && !addr_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        t_d     = tensor_size;
                        k_d     = kernel_size;
                        c_d     = channels;
                        s_d     = stride;
                        tsq_d   = ADDR_W'(tensor_size) * ADDR_W'(tensor_size);
                        st_d    = ADDR_W'(stride) * ADDR_W'(tensor_size);
                        r_d     = tensor_size - TS_W'(kernel_size);
                        q_d     = '0;
`ifdef IM2COL_STALL_CNT_EN
                        stall_d = '0;
`endif
                        state_d = S_CALC;
                    end
                end
            end

            // Floor division (T-K)/S by repeated subtraction
            S_CALC: begin
                if (RS_W'(r_q) >= RS_W'(s_q)) begin
                    r_d = r_q - TS_W'(s_q);
                    q_d = q_q + TS_W'(1);
                end else begin
                    n_ofs_d     = q_q;
                    para_done_d = 1'b1;
                    kx_d        = '0;
                    ky_d        = '0;
                    ch_d        = '0;
                    ox_d        = '0;
                    oy_d        = '0;
                    ch_base_d   = '0;
                    row_d       = '0;
                    col_d       = '0;
                    oy_row_d    = '0;
                    ox_col_d    = '0;
                    addr_d      = '0;
                    valid_d     = 1'b1;
                    row_last_d  = (c_q == CH_W'(1)) && (k_q == KS_W'(1));
                    state_d     = S_RUN;
                end
            end

            // Innermost kx, then ky, c, ox, oy; bases stepped so no multiply per address
            S_RUN: begin
                if (valid_q && addr_ready) begin
                    if (!kx_last) begin
                        kx_d  = kx_q + KS_W'(1);
                        col_d = col_q + ADDR_W'(1);
                    end else begin
                        kx_d = '0;
                        if (!ky_last) begin
                            ky_d  = ky_q + KS_W'(1);
                            row_d = row_q + ADDR_W'(t_q);
                            col_d = ox_col_q;
                        end else begin
                            ky_d = '0;
                            if (!ch_last) begin
                                ch_d      = ch_q + CH_W'(1);
                                ch_base_d = ch_base_q + tsq_q;
                                row_d     = oy_row_q;
                                col_d     = ox_col_q;
                            end else begin
                                ch_d      = '0;
                                ch_base_d = '0;
                                if (!ox_last) begin
                                    ox_d     = ox_q + TS_W'(1);
                                    ox_col_d = ox_col_q + ADDR_W'(s_q);
                                    col_d    = ox_col_q + ADDR_W'(s_q);
                                    row_d    = oy_row_q;
                                end else begin
                                    ox_d     = '0;
                                    ox_col_d = '0;
                                    col_d    = '0;
                                    if (!oy_last) begin
                                        oy_d     = oy_q + TS_W'(1);
                                        oy_row_d = oy_row_q + st_q;
                                        row_d    = oy_row_q + st_q;
                                    end else begin
                                        valid_d    = 1'b0;
                                        row_last_d = 1'b0;
                                        w_done_d   = 1'b1;
                                        state_d    = S_DONE;
                                    end
                                end
                            end
                        end
                    end
                    if (state_d == S_RUN) begin
                        addr_d     = ch_base_d + row_d + col_d;
                        row_last_d = (ch_d == c_q - CH_W'(1)) &&
                                     (ky_d == k_q - KS_W'(1)) &&
                                     (kx_d == k_q - KS_W'(1));
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            t_q         <= '0;
            k_q         <= '0;
            c_q         <= '0;
            s_q         <= '0;
            r_q         <= '0;
            q_q         <= '0;
            tsq_q       <= '0;
            st_q        <= '0;
            kx_q        <= '0;
            ky_q        <= '0;
            ch_q        <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            ch_base_q   <= '0;
            row_q       <= '0;
            col_q       <= '0;
            oy_row_q    <= '0;
            ox_col_q    <= '0;
            addr_q      <= '0;
            valid_q     <= 1'b0;
            row_last_q  <= 1'b0;
            n_ofs_q     <= '0;
            para_done_q <= 1'b0;
            w_done_q    <= 1'b0;
            cfg_err_q   <= 1'b0;
`ifdef IM2COL_STALL_CNT_EN
            stall_q     <= '0;
`endif
        end else if (enable) begin
            state_q     <= state_d;
            start_q     <= start_d;
            t_q         <= t_d;
            k_q         <= k_d;
            c_q         <= c_d;
            s_q         <= s_d;
            r_q         <= r_d;
            q_q         <= q_d;
            tsq_q       <= tsq_d;
            st_q        <= st_d;
            kx_q        <= kx_d;
            ky_q        <= ky_d;
            ch_q        <= ch_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            ch_base_q   <= ch_base_d;
            row_q       <= row_d;
            col_q       <= col_d;
            oy_row_q    <= oy_row_d;
            ox_col_q    <= ox_col_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            row_last_q  <= row_last_d;
            n_ofs_q     <= n_ofs_d;
            para_done_q <= para_done_d;
            w_done_q    <= w_done_d;
            cfg_err_q   <= cfg_err_d;
`ifdef IM2COL_STALL_CNT_EN
            stall_q     <= stall_d;
`endif
        end
    end

    assign addr        = addr_q;
    assign addr_valid  = valid_q;
    assign row_last    = row_last_q;
    assign n_ofs       = n_ofs_q;
    assign n_para_done = para_done_q;
    assign w_done      = w_done_q;
    assign cfg_err     = cfg_err_q;
`ifdef IM2COL_STALL_CNT_EN
    assign stall_cnt   = stall_q;
`endif

endmodule
